// File: rtl/typedecode_pkg.sv
// Shared decode types for the fetch stage.
// Holds the decoded opcode set, the PC-unit state enum and the sequential PC step.
package typedecode;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_ALU,
    OP_ALUI,
    OP_LOAD,
    OP_STORE,
    OP_BRANCH,
    OP_JAL,
    OP_JALR,
    OP_LUI,
    OP_AUIPC
  } opcodes_i;

  typedef enum logic [1:0] {
    RESET_S,
    RUN,
    TRAP
  } pc_state_e;

  localparam int PC_INCR = 4;

endpackage

// File: rtl/pc_unit_immgen.sv
// Immediate generator: extracts RV32 I, B and J immediates as 32-bit signed values.
// Widening to the PC width is left to the instantiating unit.
module immgen (
  input  logic [31:0] instruction_i,
  output logic [31:0] itypeimm,
  output logic [31:0] sbtypeimm,
  output logic [31:0] ujtypeimm
);

  // Opcode field is decoded elsewhere; only the immediate bits matter here.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^instruction_i[6:0];

  assign itypeimm  = {{20{instruction_i[31]}}, instruction_i[31:20]};
  assign sbtypeimm = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                      instruction_i[30:25], instruction_i[11:8], 1'b0};
  assign ujtypeimm = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                      instruction_i[20], instruction_i[30:21], 1'b0};

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch PC, selects the next PC from opcode/immediate,
// handles the imem handshake, external redirects and misaligned-target traps.
module pc_unit
  import typedecode::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100),
  parameter int              IALIGN       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  opcodes_i        opcodes,
  input  logic [31:0]     instruction_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic            stall_i,
  input  logic            imem_ready_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] link_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] trap_pc_o
);

  logic [31:0] itypeimm;
  logic [31:0] sbtypeimm;
  logic [31:0] ujtypeimm;

  immgen u_immgen (
    .instruction_i (instruction_i),
    .itypeimm      (itypeimm),
    .sbtypeimm     (sbtypeimm),
    .ujtypeimm     (ujtypeimm)
  );

  logic [XLEN-1:0] itype_x;
  logic [XLEN-1:0] sbtype_x;
  logic [XLEN-1:0] ujtype_x;

  assign itype_x  = XLEN'($signed(itypeimm));
  assign sbtype_x = XLEN'($signed(sbtypeimm));
  assign ujtype_x = XLEN'($signed(ujtypeimm));

  pc_state_e       state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] trap_pc_reg, trap_pc_next;
  logic            misalign_reg;
  logic            valid_reg;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] tgt;
  logic            tgt_misaligned;
  logic            advance;

  assign seq_pc   = pc_reg + XLEN'(PC_INCR);
  assign jalr_sum = rs1_i + itype_x;

  always_comb begin
    tgt = seq_pc;
    case (opcodes)
      OP_BRANCH: tgt = branch_taken_i ? (pc_reg + sbtype_x) : seq_pc;
      OP_JAL:    tgt = pc_reg + ujtype_x;
      OP_JALR:   tgt = {jalr_sum[XLEN-1:1], 1'b0};
      default:   tgt = seq_pc;
    endcase
  end

  // With 2-byte alignment every target is legal: bit0 is always zero by construction.
  assign tgt_misaligned = (IALIGN == 4) && tgt[1];
  assign advance        = imem_ready_i && !stall_i;

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    trap_pc_next = trap_pc_reg;
    case (state_reg)
      RESET_S: begin
        state_next = RUN;
      end
      RUN: begin
        if (flush_i) begin
          pc_next = redirect_pc_i;
        end else if (advance) begin
          if (tgt_misaligned) begin
            state_next   = TRAP;
            trap_pc_next = pc_reg;
          end else begin
            pc_next = tgt;
          end
        end
      end
      TRAP: begin
        state_next = RUN;
        pc_next    = flush_i ? redirect_pc_i : TRAP_VECTOR;
      end
      default: begin
        state_next = RESET_S;
        pc_next    = RESET_VECTOR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= RESET_S;
      pc_reg       <= RESET_VECTOR;
      trap_pc_reg  <= '0;
      misalign_reg <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      trap_pc_reg  <= trap_pc_next;
      misalign_reg <= (state_next == TRAP);
      valid_reg    <= (state_next == RUN);
    end
  end

  assign pc_o         = pc_reg;
  assign link_o       = seq_pc;
  assign trap_pc_o    = trap_pc_reg;
  assign misalign_o   = misalign_reg;
  assign imem_valid_o = valid_reg;

endmodule
